// File: rtl/baccarat_controller_if.sv
// ============================================================================
// Module     : baccarat_controller_if
// Purpose    : Link between the Baccarat control FSM and the card datapath.
//              Carries the score/third-card feedback from the datapath, the
//              six card load strobes, and the latched game result.
// Modports   : master - the controller (reads scores, drives strobes/result)
//              slave  - the datapath side (drives scores, reads strobes)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface baccarat_controller_if;
  // Datapath -> controller
  logic [3:0] pscore;      // player total 0-9
  logic [3:0] dscore;      // dealer total 0-9
  logic [3:0] pcard3;      // player third-card rank, 0 = none, 1-13 = A..K

  // Controller -> datapath
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;

  // Game result
  logic       player_win;
  logic       dealer_win;
  logic       game_done;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win, dealer_win, game_done
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win, dealer_win, game_done
  );
endinterface

`default_nettype wire

// File: rtl/baccarat_controller.sv
// ============================================================================
// Module     : baccarat_controller
// Purpose    : Control FSM for the hardware Baccarat game. Deals the four
//              opening cards, applies the third-card rules for player and
//              dealer, strobes one load per dealt card and latches the result.
// Ports      : slow_clock - system clock, state changes on the rising edge
//              resetb     - asynchronous active-low reset
//              bus        - baccarat_controller_if.master (scores in,
//                           load strobes and result out)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module baccarat_controller (
  input  wire logic             slow_clock,
  input  wire logic             resetb,
  baccarat_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_P1   = 4'd1,
    S_D1   = 4'd2,
    S_P2   = 4'd3,
    S_D2   = 4'd4,
    S_EVAL = 4'd5,
    S_P3   = 4'd6,
    S_BANK = 4'd7,
    S_D3   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_pcard3_val;   // Baccarat value of the player's third card
  logic       w_dealer_draws;

  // Face cards and tens count as zero.
  always_comb begin
    w_pcard3_val = (bus.pcard3 >= 4'd10) ? 4'd0 : bus.pcard3;
  end

  // Dealer third-card rule, keyed on the dealer's two-card total and the
  // value of the player's third card.
  always_comb begin
    w_dealer_draws = 1'b0;
    case (bus.dscore)
      4'd0, 4'd1, 4'd2: w_dealer_draws = 1'b1;
      4'd3:             w_dealer_draws = (w_pcard3_val != 4'd8);
      4'd4:             w_dealer_draws = (w_pcard3_val >= 4'd2) && (w_pcard3_val <= 4'd7);
      4'd5:             w_dealer_draws = (w_pcard3_val >= 4'd4) && (w_pcard3_val <= 4'd7);
      4'd6:             w_dealer_draws = (w_pcard3_val == 4'd6) || (w_pcard3_val == 4'd7);
      default:          w_dealer_draws = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST:  w_next_state = S_P1;
      S_P1:   w_next_state = S_D1;
      S_D1:   w_next_state = S_P2;
      S_P2:   w_next_state = S_D2;
      S_D2:   w_next_state = S_EVAL;
      S_EVAL: begin
        if ((bus.pscore >= 4'd8) || (bus.dscore >= 4'd8)) begin
          w_next_state = S_DONE;                   // natural
        end else if (bus.pscore <= 4'd5) begin
          w_next_state = S_P3;                     // player draws
        end else if (bus.dscore <= 4'd5) begin
          w_next_state = S_D3;                     // player stands, dealer draws
        end else begin
          w_next_state = S_DONE;                   // both stand
        end
      end
      S_P3:   w_next_state = S_BANK;
      S_BANK: w_next_state = w_dealer_draws ? S_D3 : S_DONE;
      S_D3:   w_next_state = S_DONE;
      S_DONE: w_next_state = S_DONE;
      default: w_next_state = S_RST;
    endcase
  end

  // Strobes are decoded from the next state so that each one is a clean
  // register output that is high for exactly the cycle spent in its state.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state         <= S_RST;
      bus.load_pcard1 <= 1'b0;
      bus.load_pcard2 <= 1'b0;
      bus.load_pcard3 <= 1'b0;
      bus.load_dcard1 <= 1'b0;
      bus.load_dcard2 <= 1'b0;
      bus.load_dcard3 <= 1'b0;
      bus.player_win  <= 1'b0;
      bus.dealer_win  <= 1'b0;
      bus.game_done   <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      bus.load_pcard1 <= (w_next_state == S_P1);
      bus.load_dcard1 <= (w_next_state == S_D1);
      bus.load_pcard2 <= (w_next_state == S_P2);
      bus.load_dcard2 <= (w_next_state == S_D2);
      bus.load_pcard3 <= (w_next_state == S_P3);
      bus.load_dcard3 <= (w_next_state == S_D3);
      // Result is captured once, on the edge that enters S_DONE, from the
      // final totals. A tie is flagged by raising both win bits.
      if ((w_next_state == S_DONE) && (r_state != S_DONE)) begin
        bus.game_done  <= 1'b1;
        bus.player_win <= (bus.pscore >= bus.dscore);
        bus.dealer_win <= (bus.dscore >= bus.pscore);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_baccarat_controller.sv
// ============================================================================
// Module     : tb_baccarat_controller
// Purpose    : Self-checking bench for baccarat_controller. A small datapath
//              model deals cards from a per-game deck; a reference model of
//              the Baccarat rules queues the expected strobes and result, and
//              a monitor pops and compares whenever the DUT presents them.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baccarat_controller;

  logic clk    = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  baccarat_controller_if bus ();

  baccarat_controller dut (
    .slow_clock (clk),
    .resetb     (resetb),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  // Rising edges since reset release: during cycle k this reads k.
  int cyc = 0;
  always @(posedge clk or negedge resetb) begin
    if (!resetb) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // ---------------- datapath model ----------------
  // deck order: P1, D1, P2, D2, P3, D3
  logic [3:0] deck [6];
  logic [3:0] pc [3];
  logic [3:0] dc [3];

  function automatic int cval(input logic [3:0] r);
    return (r >= 4'd10) ? 0 : int'(r);
  endfunction

  always @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 3; i++) begin
        pc[i] <= 4'd0;
        dc[i] <= 4'd0;
      end
    end else begin
      if (bus.load_pcard1) pc[0] <= deck[0];
      if (bus.load_dcard1) dc[0] <= deck[1];
      if (bus.load_pcard2) pc[1] <= deck[2];
      if (bus.load_dcard2) dc[1] <= deck[3];
      if (bus.load_pcard3) pc[2] <= deck[4];
      if (bus.load_dcard3) dc[2] <= deck[5];
    end
  end

  always_comb begin
    bus.pscore = 4'((cval(pc[0]) + cval(pc[1]) + cval(pc[2])) % 10);
    bus.dscore = 4'((cval(dc[0]) + cval(dc[1]) + cval(dc[2])) % 10);
    bus.pcard3 = pc[2];
  end

  // ---------------- reference model + scoreboard ----------------
  // kind 0..5 = strobe P1,D1,P2,D2,P3,D3; kind 6 = result
  typedef struct {
    int kind;
    int cyc;
    bit pw;
    bit dw;
  } exp_t;
  exp_t q[$];

  function automatic bit dealer_rule(input int d, input int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d == 4) return v inside {[2:7]};
    if (d == 5) return v inside {[4:7]};
    if (d == 6) return v inside {6, 7};
    return 1'b0;
  endfunction

  task automatic push_expected();
    int p, d, done_edge;
    for (int k = 0; k < 4; k++) q.push_back('{k, k + 1, 1'b0, 1'b0});
    p = (cval(deck[0]) + cval(deck[2])) % 10;
    d = (cval(deck[1]) + cval(deck[3])) % 10;
    if (p >= 8 || d >= 8) begin
      done_edge = 6;
    end else if (p <= 5) begin
      q.push_back('{4, 6, 1'b0, 1'b0});
      if (dealer_rule(d, cval(deck[4]))) begin
        q.push_back('{5, 8, 1'b0, 1'b0});
        d = (d + cval(deck[5])) % 10;
        done_edge = 9;
      end else begin
        done_edge = 8;
      end
      p = (p + cval(deck[4])) % 10;
    end else if (d <= 5) begin
      q.push_back('{5, 6, 1'b0, 1'b0});
      d = (d + cval(deck[5])) % 10;
      done_edge = 7;
    end else begin
      done_edge = 6;
    end
    q.push_back('{6, done_edge, (p > d) || (p == d), (d > p) || (p == d)});
  endtask

  // ---------------- monitor ----------------
  logic [5:0] mon_s;
  int         mon_k;
  exp_t       mon_e;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    if (!resetb) begin
      prev_done = 1'b0;
    end else begin
      mon_s = {bus.load_dcard3, bus.load_pcard3, bus.load_dcard2,
               bus.load_pcard2, bus.load_dcard1, bus.load_pcard1};
      if (mon_s != 6'd0) begin
        checks++;
        mon_k = -1;
        for (int i = 0; i < 6; i++) if (mon_s[i]) mon_k = i;
        if ($countones(mon_s) != 1) begin
          errors++;
          $display("FAIL strobe_onehot: strobes=%b at cycle %0d, required exactly one", mon_s, cyc);
        end else if (q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: strobe %0d at cycle %0d, required none", mon_k, cyc);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.kind != mon_k || mon_e.cyc != cyc) begin
            errors++;
            $display("FAIL strobe_seq: got strobe %0d at cycle %0d, required strobe %0d at cycle %0d",
                     mon_k, cyc, mon_e.kind, mon_e.cyc);
          end
        end
      end
      if (bus.game_done && !prev_done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: game_done at cycle %0d, required none", cyc);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.kind != 6 || mon_e.cyc != cyc ||
              bus.player_win != mon_e.pw || bus.dealer_win != mon_e.dw) begin
            errors++;
            $display("FAIL result: got done@%0d pw=%0b dw=%0b, required kind %0d done@%0d pw=%0b dw=%0b",
                     cyc, bus.player_win, bus.dealer_win, mon_e.kind, mon_e.cyc, mon_e.pw, mon_e.dw);
          end
        end
      end
      prev_done = bus.game_done;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [8:0] all_outputs();
    return {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
            bus.load_dcard1, bus.load_dcard2, bus.load_dcard3,
            bus.player_win, bus.dealer_win, bus.game_done};
  endfunction

  task automatic check_outputs_zero(input string name);
    checks++;
    if (all_outputs() != 9'd0) begin
      errors++;
      $display("FAIL %s: outputs=%b, required all zero", name, all_outputs());
    end
  endtask

  task automatic start_game(input logic [3:0] p1, d1, p2, d2, p3, d3);
    resetb = 1'b0;
    deck[0] = p1; deck[1] = d1; deck[2] = p2;
    deck[3] = d2; deck[4] = p3; deck[5] = d3;
    q.delete();
    push_expected();
    @(posedge clk);
    #($urandom_range(1, 8));
    resetb = 1'b1;
  endtask

  task automatic finish_game();
    int n;
    n = 0;
    while (!bus.game_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.game_done) begin
      errors++;
      $display("FAIL done_timeout: game_done=0 after %0d cycles, required 1", n);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0 || !bus.game_done) begin
      errors++;
      $display("FAIL game_end: %0d expected events left, game_done=%0b, required 0 left and 1",
               q.size(), bus.game_done);
    end
    #2 resetb = 1'b0;
    #1 check_outputs_zero("async_reset");
  endtask

  task automatic play(input logic [3:0] p1, d1, p2, d2, p3, d3);
    start_game(p1, d1, p2, d2, p3, d3);
    finish_game();
  endtask

  task automatic play_random();
    play(4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
         4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
         4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)));
  endtask

  initial begin
    int n;
    logic [3:0] d1r;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");

    // Natural: player 9, dealer 3
    play(4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd6);
    // Both stand 7/7 -> tie
    play(4'd3, 4'd3, 4'd4, 4'd4, 4'd1, 4'd1);
    // Player stands on 6, dealer 4 draws a 3 -> 7
    play(4'd2, 4'd1, 4'd4, 4'd3, 4'd9, 4'd3);
    // Player draws, dealer 3: third card 8 (stand) and queen (draw)
    play(4'd1, 4'd1, 4'd1, 4'd2, 4'd8, 4'd5);
    play(4'd1, 4'd1, 4'd1, 4'd2, 4'd12, 4'd5);

    // Dealer rule sweep: player total 1, dealer total 0..7, third card A..K
    for (int d = 0; d < 8; d++) begin
      for (int c = 1; c <= 13; c++) begin
        d1r = (d == 0) ? 4'd10 : 4'(d);
        play(4'd1, d1r, 4'd13, 4'd13, 4'(c), 4'($urandom_range(1, 13)));
      end
    end

    // Reset asserted mid-game during S_P3, then the same game replayed
    start_game(4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd4);
    n = 0;
    while (cyc != 6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.load_pcard3) begin
      errors++;
      $display("FAIL midgame_p3: load_pcard3=%0b at cycle %0d, required 1 at cycle 6", bus.load_pcard3, cyc);
    end
    #1 resetb = 1'b0;
    #1 check_outputs_zero("midgame_reset");
    q.delete();
    play(4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd4);

    // Random games
    for (int g = 0; g < 150; g++) play_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
